id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage pipeline. It captures the decoded control bits from `ctrl` along with the decode-stage operands, and presents them to EX one cycle later. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble and stalls PC and IF/ID. It also clears its contents on a taken-branch flush and keeps saturating stall/flush event counters for bring-up.

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_reg_dst,
    input  logic                      id_alu_src,
    input  logic                      id_branch,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_reg_src,
    input  logic                      id_reg_write,
    input  logic [1:0]                id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [5:0]                id_funct,
    input  logic                      flush,
    output logic                      ex_reg_dst,
    output logic                      ex_alu_src,
    output logic                      ex_branch,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_reg_src,
    output logic                      ex_reg_write,
    output logic [1:0]                ex_alu_op,
    output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
    output logic [DATA_WIDTH-1:0]     ex_rs_data,
    output logic [DATA_WIDTH-1:0]     ex_rt_data,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [5:0]                ex_funct,
    output logic                      ex_valid,
    output logic                      stall,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    // ALU operand B selects the rt register when alu_src is 0.
    localparam logic FROM_RT = 1'b0;

    // Control packed as {reg_dst, alu_src, branch, mem_read, mem_write, reg_src, reg_write, alu_op[1:0]}
    logic [8:0]                ctrl_q, ctrl_d;
    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]                funct_q, funct_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic                      rt_used, load_use, bubble;

    // reg_dst/reg_src are deliberately kept out of the hazard path.
    assign rt_used  = (id_alu_src == FROM_RT) | id_mem_write;
    assign load_use = valid_q & ctrl_q[5] & (rt_q != '0) &
                      ((rt_q == id_rs) | (rt_used & (rt_q == id_rt)));
    assign stall    = load_use & ~flush;
    assign bubble   = flush | load_use;

    always_comb begin
        ctrl_d      = bubble ? '0 : {id_reg_dst, id_alu_src, id_branch, id_mem_read,
                                     id_mem_write, id_reg_src, id_reg_write, id_alu_op};
        valid_d     = ~bubble;
        pc_d        = id_pc_plus4;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        rs_d        = id_rs;
        rt_d        = id_rt;
        rd_d        = id_rd;
        funct_d     = id_funct;
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_WIDTH'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            funct_q     <= funct_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read,
            ex_mem_write, ex_reg_src, ex_reg_write, ex_alu_op} = ctrl_q;
    assign ex_valid    = valid_q;
    assign ex_pc_plus4 = pc_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_funct    = funct_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    // {reg_dst, alu_src, branch, mem_read, mem_write, reg_src, reg_write, alu_op}
    localparam logic [8:0] C_ADD = 9'b1_0_0_0_0_0_1_10;
    localparam logic [8:0] C_LW  = 9'b0_1_0_1_0_1_1_00;
    localparam logic [8:0] C_SW  = 9'b0_1_0_0_1_0_0_00;
    localparam logic [8:0] C_0   = 9'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write, id_reg_src, id_reg_write;
    logic [1:0] id_alu_op;
    logic [DW-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [5:0] id_funct;
    logic flush;
    logic ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_reg_src, ex_reg_write;
    logic [1:0] ex_alu_op;
    logic [DW-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [5:0] ex_funct;
    logic ex_valid, stall;
    logic [CW-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_src(id_reg_src),
        .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .flush(flush),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_src(ex_reg_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
        .ex_valid(ex_valid), .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            step;
        logic          valid;
        logic [8:0]    ctrl;
        logic [DW-1:0] pc, rs_data, rt_data, imm;
        logic [AW-1:0] rs, rt, rd;
        logic [5:0]    funct;
        logic          stall;
        int            scnt, fcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Data fields of the previously applied vector (they load even into bubbles).
    logic          prev_rst = 1'b1;
    logic [DW-1:0] p_pc, p_rsd, p_rtd, p_imm;
    logic [AW-1:0] p_rs, p_rt, p_rd;
    logic [5:0]    p_fn;

    task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, step, act, exp);
    endtask

    task automatic apply(input logic r, input logic fl, input logic [8:0] c,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [DW-1:0] rsd, input int step);
        rst   = r;
        flush = fl;
        {id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write,
         id_reg_src, id_reg_write, id_alu_op} = c;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_rs_data  = rsd;
        id_rt_data  = rsd ^ 32'hA5A5_A5A5;
        id_imm      = rsd + 32'd4;
        id_pc_plus4 = 32'h400 + 32'(step) * 32'd4;
        id_funct    = 6'(rd) + 6'd32;
    endtask

    task automatic drive(input int step, input logic r, input logic fl, input logic [8:0] c,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [DW-1:0] rsd,
                         input logic ev, input logic [8:0] ec, input logic est, input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        e.step  = step;
        e.valid = ev;
        e.ctrl  = ec;
        e.stall = est;
        e.scnt  = esc;
        e.fcnt  = efc;
        if (prev_rst) begin
            e.pc = '0; e.rs_data = '0; e.rt_data = '0; e.imm = '0;
            e.rs = '0; e.rt = '0; e.rd = '0; e.funct = '0;
        end else begin
            e.pc = p_pc; e.rs_data = p_rsd; e.rt_data = p_rtd; e.imm = p_imm;
            e.rs = p_rs; e.rt = p_rt; e.rd = p_rd; e.funct = p_fn;
        end
        apply(r, fl, c, rs, rt, rd, rsd, step);
        prev_rst = r;
        p_pc = id_pc_plus4; p_rsd = id_rs_data; p_rtd = id_rt_data; p_imm = id_imm;
        p_rs = rs; p_rt = rt; p_rd = rd; p_fn = id_funct;
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ex_valid",  e.step, 32'(ex_valid), 32'(e.valid));
                chk("ex_ctrl",   e.step, 32'({ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read,
                                              ex_mem_write, ex_reg_src, ex_reg_write, ex_alu_op}), 32'(e.ctrl));
                chk("ex_pc",     e.step, ex_pc_plus4, e.pc);
                chk("ex_rs_data",e.step, ex_rs_data, e.rs_data);
                chk("ex_rt_data",e.step, ex_rt_data, e.rt_data);
                chk("ex_imm",    e.step, ex_imm, e.imm);
                chk("ex_regs",   e.step, 32'({ex_rs, ex_rt, ex_rd}), 32'({e.rs, e.rt, e.rd}));
                chk("ex_funct",  e.step, 32'(ex_funct), 32'(e.funct));
                chk("stall",     e.step, 32'(stall), 32'(e.stall));
                chk("stall_cnt", e.step, 32'(stall_cnt), 32'(e.scnt));
                chk("flush_cnt", e.step, 32'(flush_cnt), 32'(e.fcnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        apply(1'b1, 1'b0, 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 0);
        //     step r  fl  ctrl   rs  rt  rd  rs_data        ev  exp_ctrl st scnt fcnt
        drive(1,  1, 0, 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
              0, C_0, 0, 0, 0);
        drive(2,  1, 0, 9'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
              0, C_0, 0, 0, 0);
        drive(3,  0, 0, C_ADD, 1, 2, 3,  32'h1234_5678, 0, C_0,   0, 0, 0);
        drive(4,  0, 0, C_LW,  2, 5, 0,  32'h0000_0011, 1, C_ADD, 0, 0, 0);
        drive(5,  0, 0, C_ADD, 5, 6, 7,  32'h0000_0022, 1, C_LW,  1, 0, 0);
        drive(6,  0, 0, C_ADD, 5, 6, 7,  32'h0000_0033, 0, C_0,   0, 1, 0);
        drive(7,  0, 0, C_LW,  0, 0, 0,  32'h0000_0044, 1, C_ADD, 0, 1, 0);
        drive(8,  0, 0, C_ADD, 0, 0, 9,  32'h0000_0055, 1, C_LW,  0, 1, 0);
        drive(9,  0, 0, C_LW,  1, 7, 0,  32'h0000_0066, 1, C_ADD, 0, 1, 0);
        drive(10, 0, 0, C_LW,  3, 7, 0,  32'h0000_0077, 1, C_LW,  0, 1, 0);
        drive(11, 0, 0, C_SW,  4, 7, 0,  32'h0000_0088, 1, C_LW,  1, 1, 0);
        drive(12, 0, 0, C_SW,  4, 7, 0,  32'h0000_0099, 0, C_0,   0, 2, 0);
        drive(13, 0, 0, C_ADD, 9, 10, 1, 32'h0000_00AA, 1, C_SW,  0, 2, 0);
        drive(14, 0, 0, C_LW,  1, 8, 0,  32'h0000_00BB, 1, C_ADD, 0, 2, 0);
        drive(15, 0, 1, C_ADD, 8, 2, 4,  32'h0000_00CC, 1, C_LW,  0, 2, 0);
        drive(16, 0, 0, C_ADD, 8, 2, 4,  32'h0000_00DD, 0, C_0,   0, 2, 1);
        drive(17, 0, 1, C_ADD, 1, 2, 4,  32'h0000_00EE, 1, C_ADD, 0, 2, 1);
        drive(18, 0, 1, C_ADD, 1, 2, 4,  32'h0000_00FF, 0, C_0,   0, 2, 2);
        drive(19, 0, 0, C_ADD, 1, 2, 4,  32'h0000_0100, 0, C_0,   0, 2, 3);
        drive(20, 0, 0, C_ADD, 1, 2, 4,  32'h0000_0111, 1, C_ADD, 0, 2, 3);
        drive(21, 0, 0, C_LW,  1, 11, 0, 32'h0000_0122, 1, C_ADD, 0, 2, 3);
        drive(22, 0, 0, C_LW,  11, 12, 0,32'h0000_0133, 1, C_LW,  1, 2, 3);
        drive(23, 0, 0, C_LW,  11, 12, 0,32'h0000_0144, 0, C_0,   0, 3, 3);
        drive(24, 1, 0, C_ADD, 12, 3, 5, 32'h0000_0155, 1, C_LW,  1, 3, 3);
        drive(25, 0, 0, C_ADD, 12, 3, 5, 32'h0000_0166, 0, C_0,   0, 0, 0);
        drive(26, 0, 0, C_ADD, 12, 3, 5, 32'h0000_0177, 1, C_ADD, 0, 0, 0);
        // 20 load-use events drive the 4-bit stall counter into saturation.
        for (int k = 0; k < 20; k++) begin
            sc = (k < 15) ? k : 15;
            drive(100 + 3*k, 0, 0, C_LW,  1, 5, 0, 32'(k),         1, C_ADD, 0, sc, 0);
            drive(101 + 3*k, 0, 0, C_ADD, 5, 6, 7, 32'(k) + 32'h10, 1, C_LW,  1, sc, 0);
            sc = (k + 1 < 15) ? k + 1 : 15;
            drive(102 + 3*k, 0, 0, C_ADD, 5, 6, 7, 32'(k) + 32'h20, 0, C_0,   0, sc, 0);
        end
        drive(200, 0, 0, C_ADD, 1, 2, 3, 32'h0000_0200, 1, C_ADD, 0, 15, 0);
        for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
